// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // Bytes per memory word
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Combinational lane steering: legality check, byte enables, store-lane
// replication and load extraction/extension for one 32-bit memory word.
module dmem_lane_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [31:0]           mem_word_i,
    output logic [3:0]            be_o,
    output logic [31:0]           wword_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misalignment and illegal-encoding detection
    always_comb begin
        err_o = 1'b0;
        case (funct3_i)
            LS_B:    err_o = 1'b0;
            LS_H:    err_o = addr_lo_i[0];
            LS_W:    err_o = (addr_lo_i != 2'b00);
            LS_BU:   err_o = we_i;
            LS_HU:   err_o = we_i | addr_lo_i[0];
            default: err_o = 1'b1;
        endcase
    end

    // Byte enables and store data replicated across every lane
    always_comb begin
        be_o    = '0;
        wword_o = '0;
        case (funct3_i)
            LS_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            LS_H: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
            end
            LS_W: begin
                be_o    = 4'b1111;
                wword_o = wdata_i[31:0];
            end
            default: begin
                be_o    = '0;
                wword_o = '0;
            end
        endcase
        if (!we_i || err_o) begin
            be_o = '0;
        end
    end

    // Load lane selection with sign or zero extension
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = mem_word_i[7:0];
            2'd1:    byte_sel = mem_word_i[15:8];
            2'd2:    byte_sel = mem_word_i[23:16];
            default: byte_sel = mem_word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

        rdata_o = '0;
        case (funct3_i)
            LS_B:    rdata_o = DATA_WIDTH'($signed(byte_sel));
            LS_H:    rdata_o = DATA_WIDTH'($signed(half_sel));
            LS_W:    rdata_o = DATA_WIDTH'(mem_word_i);
            LS_BU:   rdata_o = DATA_WIDTH'(byte_sel);
            LS_HU:   rdata_o = DATA_WIDTH'(half_sel);
            default: rdata_o = '0;
        endcase
        if (we_i || err_o) begin
            rdata_o = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, programmable wait states,
// byte-addressed little-endian storage with a registered response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 17,
    parameter int WAIT_STATES   = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int unsigned WORDS    = 2 ** (ADDRESS_WIDTH - 2);
    localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e                   state_q;
    logic [3:0]               cnt_q;
    logic                     we_q;
    logic [2:0]               funct3_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     rsp_valid_q;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q;
    logic                     rsp_err_q;

    logic [31:0]              mem_q [WORDS];

    logic                     accept;
    logic                     enter_resp;
    logic                     acc_we;
    logic [2:0]               acc_funct3;
    logic [ADDRESS_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0]    acc_wdata;
    logic [31:0]              mem_word;
    logic [3:0]               lane_be;
    logic [31:0]              lane_wword;
    logic [DATA_WIDTH-1:0]    rdata_d;
    logic                     err_d;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Access-commit qualifiers; reset at the same edge cancels the access
    always_comb begin
        accept     = req_valid && (state_q == IDLE);
        enter_resp = !RST && ((accept && (WAIT_STATES == 0)) ||
                              ((state_q == WAIT) && (cnt_q == 4'd0)));
    end

    // With zero wait states the access happens on the accept edge itself,
    // so the lane logic must see the live request instead of the latched copy
    always_comb begin
        if (state_q == IDLE) begin
            acc_we     = req_we;
            acc_funct3 = req_funct3;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
        end else begin
            acc_we     = we_q;
            acc_funct3 = funct3_q;
            acc_addr   = addr_q;
            acc_wdata  = wdata_q;
        end
        mem_word = mem_q[acc_addr[ADDRESS_WIDTH-1:2]];
    end

    dmem_lane_ctrl #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_ctrl (
        .we_i       (acc_we),
        .funct3_i   (acc_funct3),
        .addr_lo_i  (acc_addr[1:0]),
        .wdata_i    (acc_wdata),
        .mem_word_i (mem_word),
        .be_o       (lane_be),
        .wword_o    (lane_wword),
        .rdata_o    (rdata_d),
        .err_o      (err_d)
    );

    // Byte-lane store commit; contents are deliberately not reset
    always_ff @(posedge CLK) begin
        if (enter_resp) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                if (lane_be[i]) begin
                    mem_q[acc_addr[ADDRESS_WIDTH-1:2]][i*8 +: 8] <= lane_wword[i*8 +: 8];
                end
            end
        end
    end

    // Request/wait/response sequencing with registered response outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (WAIT_STATES == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rdata_d;
                            rsp_err_q   <= err_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_d;
                        rsp_err_q   <= err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_STATES=1 and 3).
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk;
    logic        rst1, rst3;
    logic        v1, v3;
    logic        we;
    logic [2:0]  f3;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic        rsp_ready;

    logic        r1_ready, r1_valid, r1_err;
    logic [31:0] r1_rdata;
    logic        r3_ready, r3_valid, r3_err;
    logic [31:0] r3_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (17),
        .WAIT_STATES   (1)
    ) u_ws1 (
        .CLK        (clk),
        .RST        (rst1),
        .req_valid  (v1),
        .req_ready  (r1_ready),
        .req_we     (we),
        .req_funct3 (f3),
        .req_addr   (addr),
        .req_wdata  (wdata),
        .rsp_valid  (r1_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (r1_rdata),
        .rsp_err    (r1_err)
    );

    dmem_responder #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (17),
        .WAIT_STATES   (3)
    ) u_ws3 (
        .CLK        (clk),
        .RST        (rst3),
        .req_valid  (v3),
        .req_ready  (r3_ready),
        .req_we     (we),
        .req_funct3 (f3),
        .req_addr   (addr),
        .req_wdata  (wdata),
        .rsp_valid  (r3_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (r3_rdata),
        .rsp_err    (r3_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e_v);
        checks++;
        assert (obs === e_v) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, e_v);
        end
    endtask

    function automatic logic cur_ready(input int sel);
        return (sel == 3) ? r3_ready : r1_ready;
    endfunction

    function automatic logic cur_valid(input int sel);
        return (sel == 3) ? r3_valid : r1_valid;
    endfunction

    function automatic logic [31:0] cur_rdata(input int sel);
        return (sel == 3) ? r3_rdata : r1_rdata;
    endfunction

    function automatic logic cur_err(input int sel);
        return (sel == 3) ? r3_err : r1_err;
    endfunction

    // One request/response. Latency counts cycles from the accept cycle to the
    // first cycle with rsp_valid, so the required value is 1+WAIT_STATES.
    task automatic txn(input int sel, input string tag, input logic w, input logic [2:0] f,
                       input logic [16:0] a, input logic [31:0] d, input int stall,
                       input logic [31:0] e_rd, input logic e_err);
        int          lat;
        logic [31:0] held;
        @(negedge clk);
        chk({tag, "/req_ready"}, 32'(cur_ready(sel)), 32'd1);
        we        = w;
        f3        = f;
        addr      = a;
        wdata     = d;
        rsp_ready = (stall == 0);
        if (sel == 3) v3 = 1'b1; else v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        v3 = 1'b0;
        lat = 1;
        while (!cur_valid(sel) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), (sel == 3) ? 32'd4 : 32'd2);
        chk({tag, "/rdata"}, cur_rdata(sel), e_rd);
        chk({tag, "/err"}, 32'(cur_err(sel)), 32'(e_err));
        if (stall > 0) begin
            held = cur_rdata(sel);
            // a competing store presented while busy must be ignored
            we = 1'b1; f3 = LS_W; addr = 17'h00100; wdata = 32'h0;
            if (sel == 3) v3 = 1'b1; else v1 = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                chk({tag, "/stall_valid"}, 32'(cur_valid(sel)), 32'd1);
                chk({tag, "/stall_rdata"}, cur_rdata(sel), held);
                chk({tag, "/stall_ready"}, 32'(cur_ready(sel)), 32'd0);
            end
            @(negedge clk);
            v1 = 1'b0;
            v3 = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "/post_valid"}, 32'(cur_valid(sel)), 32'd0);
        chk({tag, "/post_ready"}, 32'(cur_ready(sel)), 32'd1);
    endtask

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        v1 = 1'b0; v3 = 1'b0;
        we = 1'b0; f3 = LS_W; addr = '0; wdata = '0;
        rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst/ready1", 32'(r1_ready), 32'd1);
        chk("rst/valid1", 32'(r1_valid), 32'd0);
        chk("rst/rdata1", r1_rdata, 32'd0);
        chk("rst/err1",   32'(r1_err), 32'd0);
        chk("rst/ready3", 32'(r3_ready), 32'd1);
        chk("rst/valid3", 32'(r3_valid), 32'd0);
        @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;

        // word store/load and extensions
        txn(1, "sw100",  1'b1, LS_W,  17'h00100, 32'hDEADBEEF, 0, 32'h00000000, 1'b0);
        txn(1, "lw100",  1'b0, LS_W,  17'h00100, 32'h0,        0, 32'hDEADBEEF, 1'b0);
        txn(1, "lb103",  1'b0, LS_B,  17'h00103, 32'h0,        0, 32'hFFFFFFDE, 1'b0);
        txn(1, "lbu103", 1'b0, LS_BU, 17'h00103, 32'h0,        0, 32'h000000DE, 1'b0);
        txn(1, "lhu102", 1'b0, LS_HU, 17'h00102, 32'h0,        0, 32'h0000DEAD, 1'b0);
        txn(1, "lh100",  1'b0, LS_H,  17'h00100, 32'h0,        0, 32'hFFFFBEEF, 1'b0);

        // byte store into lane 1
        txn(1, "sb101",  1'b1, LS_B,  17'h00101, 32'h00000012, 0, 32'h00000000, 1'b0);
        txn(1, "lw100b", 1'b0, LS_W,  17'h00100, 32'h0,        0, 32'hDEAD12EF, 1'b0);

        // errors: no write, rdata 0, normal latency
        txn(1, "sw102e", 1'b1, LS_W,  17'h00102, 32'h00000001, 0, 32'h00000000, 1'b1);
        txn(1, "lh101e", 1'b0, LS_H,  17'h00101, 32'h0,        0, 32'h00000000, 1'b1);
        txn(1, "f011e",  1'b0, 3'b011, 17'h00100, 32'h0,       0, 32'h00000000, 1'b1);
        txn(1, "sbu_e",  1'b1, LS_BU, 17'h00100, 32'h00000055, 0, 32'h00000000, 1'b1);
        txn(1, "lw100c", 1'b0, LS_W,  17'h00100, 32'h0,        0, 32'hDEAD12EF, 1'b0);

        // response held under back-pressure, busy-time requests ignored
        txn(1, "stall",  1'b0, LS_W,  17'h00100, 32'h0,        5, 32'hDEAD12EF, 1'b0);
        txn(1, "lw100d", 1'b0, LS_W,  17'h00100, 32'h0,        0, 32'hDEAD12EF, 1'b0);

        // half store into upper lanes; upper wdata bits ignored
        txn(1, "sh102",  1'b1, LS_H,  17'h00102, 32'hABCD8001, 0, 32'h00000000, 1'b0);
        txn(1, "lw100e", 1'b0, LS_W,  17'h00100, 32'h0,        0, 32'h800112EF, 1'b0);
        txn(1, "lh102",  1'b0, LS_H,  17'h00102, 32'h0,        0, 32'hFFFF8001, 1'b0);

        // top of memory, no wrap into address 0
        txn(1, "sw000",  1'b1, LS_W,  17'h00000, 32'h01020304, 0, 32'h00000000, 1'b0);
        txn(1, "swtop",  1'b1, LS_W,  17'h1FFFC, 32'hCAFEF00D, 0, 32'h00000000, 1'b0);
        txn(1, "lwtop",  1'b0, LS_W,  17'h1FFFC, 32'h0,        0, 32'hCAFEF00D, 1'b0);
        txn(1, "lbtop",  1'b0, LS_B,  17'h1FFFF, 32'h0,        0, 32'hFFFFFFCA, 1'b0);
        txn(1, "lw000",  1'b0, LS_W,  17'h00000, 32'h0,        0, 32'h01020304, 1'b0);

        // WAIT_STATES=3: reset during WAIT aborts the store
        txn(3, "w3sw200", 1'b1, LS_W, 17'h00200, 32'h11223344, 0, 32'h00000000, 1'b0);
        @(negedge clk);
        we = 1'b1; f3 = LS_W; addr = 17'h00200; wdata = 32'h000000AA;
        rsp_ready = 1'b1;
        v3 = 1'b1;
        @(posedge clk); #1;
        v3 = 1'b0;
        chk("abort/ready_wait", 32'(r3_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort/valid_wait", 32'(r3_valid), 32'd0);
        @(negedge clk);
        rst3 = 1'b1;
        @(posedge clk); #1;
        chk("abort/ready_idle", 32'(r3_ready), 32'd1);
        chk("abort/valid_idle", 32'(r3_valid), 32'd0);
        chk("abort/err_idle",   32'(r3_err), 32'd0);
        @(negedge clk);
        rst3 = 1'b0;
        txn(3, "w3lw200", 1'b0, LS_W, 17'h00200, 32'h0, 0, 32'h11223344, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
